// File: rtl/sync_fifo_vr_pkg.sv
// Package for sync_fifo_vr: parameter defaults and read-mode constants.
// No ports.
`include "include.vh"

package sync_fifo_vr_pkg;

   localparam int DEF_LEN_DATA = `LEN_FIFO_DATA;
   localparam int DEF_LEN_ADDR = `LEN_RING_BUF_ADDR;

   localparam int MODE_FWFT = `FIFO_MODE_FWFT;
   localparam int MODE_REQ  = `FIFO_MODE_REQ;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array for sync_fifo_vr.
// Synchronous write, asynchronous read, no reset (maps to distributed RAM).
// Ports:
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module fifo_mem #(
   parameter int LEN_DATA = 8,
   parameter int LEN_ADDR = 4
) (
   input  logic                clk,
   input  logic                we,
   input  logic [LEN_ADDR-1:0] waddr,
   input  logic [LEN_DATA-1:0] wdata,
   input  logic [LEN_ADDR-1:0] raddr,
   output logic [LEN_DATA-1:0] rdata
);

   logic [LEN_DATA-1:0] mem [2**LEN_ADDR];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/include.vh
// Shared build-wide defaults for the ring-buffer / FIFO family.
//   LEN_RING_BUF_ADDR : default FIFO address width (depth = 2**width)
//   LEN_FIFO_DATA     : default FIFO data width
//   FIFO_MODE_FWFT    : read mode value for first-word-fall-through
//   FIFO_MODE_REQ     : read mode value for request/done reads
`ifndef SYNC_FIFO_INCLUDE_VH
`define SYNC_FIFO_INCLUDE_VH

`define LEN_RING_BUF_ADDR 4
`define LEN_FIFO_DATA     8
`define FIFO_MODE_FWFT    1
`define FIFO_MODE_REQ     0

`endif

// File: rtl/sync_fifo_vr.sv
// Parametrised synchronous FIFO with valid/ready handshakes.
// Uses the full 2**LEN_ADDR capacity (extra pointer MSB distinguishes full
// from empty). Two read modes: first-word-fall-through or request/done.
// Ports:
//   clk         : clock
//   rstn        : synchronous active-low reset
//   flush       : synchronous clear of contents
//   i_valid     : write request
//   i_data      : write data
//   i_ready     : FIFO can accept a write (registered)
//   o_ready     : FWFT: consumer takes head; REQ: read request
//   o_valid     : FWFT: head valid; REQ: one-cycle read-done pulse
//   o_data      : read data
//   count       : occupancy 0..DEPTH
//   almost_full : count >= AFULL_TH (registered)
//   overflow    : sticky, write attempted while not ready
module sync_fifo_vr
   import sync_fifo_vr_pkg::*;
#(
   parameter int LEN_DATA = DEF_LEN_DATA,
   parameter int LEN_ADDR = DEF_LEN_ADDR,
   parameter int AFULL_TH = (2**LEN_ADDR) - 2,
   parameter int FWFT     = MODE_FWFT
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                flush,
   input  logic                i_valid,
   input  logic [LEN_DATA-1:0] i_data,
   output logic                i_ready,
   input  logic                o_ready,
   output logic                o_valid,
   output logic [LEN_DATA-1:0] o_data,
   output logic [LEN_ADDR:0]   count,
   output logic                almost_full,
   output logic                overflow
);

   localparam int              DEPTH   = 2**LEN_ADDR;
   localparam logic [LEN_ADDR:0] DEPTH_C = (LEN_ADDR+1)'(DEPTH);
   localparam logic [LEN_ADDR:0] AFULL_C = (LEN_ADDR+1)'(AFULL_TH);
   localparam bit              IS_FWFT = (FWFT == MODE_FWFT);

   logic [LEN_ADDR:0]   wr_ptr;
   logic [LEN_ADDR:0]   rd_ptr;
   logic [LEN_ADDR:0]   count_nxt;
   logic                empty;
   logic                full;
   logic                push;
   logic                pop;
   logic [LEN_DATA-1:0] mem_rdata;
   logic [LEN_DATA-1:0] rd_word_q;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[LEN_ADDR] != rd_ptr[LEN_ADDR]) &&
                  (wr_ptr[LEN_ADDR-1:0] == rd_ptr[LEN_ADDR-1:0]);

   // i_ready already excludes the full case; the pointer check is a backstop.
   assign push = i_valid & i_ready & ~full;

   // REQ mode: a read on an empty FIFO with a write in the same cycle
   // bypasses the array, so both pointers advance and count stays put.
   assign pop = IS_FWFT ? (o_valid & o_ready)
                        : (o_ready & (~empty | push));

   assign count_nxt = count + (LEN_ADDR+1)'(push) - (LEN_ADDR+1)'(pop);

   fifo_mem #(
      .LEN_DATA (LEN_DATA),
      .LEN_ADDR (LEN_ADDR)
   ) u_mem (
      .clk   (clk),
      .we    (push & rstn & ~flush),
      .waddr (wr_ptr[LEN_ADDR-1:0]),
      .wdata (i_data),
      .raddr (rd_ptr[LEN_ADDR-1:0]),
      .rdata (mem_rdata)
   );

   // FWFT output is gated so that unwritten memory never reaches o_data.
   assign o_data = IS_FWFT ? (o_valid ? mem_rdata : '0) : rd_word_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         i_ready     <= 1'b0;
         o_valid     <= 1'b0;
         almost_full <= 1'b0;
         overflow    <= 1'b0;
         rd_word_q   <= '0;
      end else if (flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         i_ready     <= 1'b1;
         o_valid     <= 1'b0;
         almost_full <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count       <= count_nxt;
         i_ready     <= (count_nxt < DEPTH_C);
         almost_full <= (count_nxt >= AFULL_C);
         if (i_valid & ~i_ready) begin
            overflow <= 1'b1;
         end
         if (IS_FWFT) begin
            o_valid <= (count_nxt != '0);
         end else begin
            o_valid <= pop;
            if (pop) begin
               rd_word_q <= empty ? i_data : mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_sync_fifo_vr.sv
// Testbench for sync_fifo_vr: one FWFT instance and one request-mode
// instance (both depth 4). Expected words go into per-instance queues
// when a write is accepted by the reference model; monitors pop and
// compare whenever the DUT presents a word.
module tb_sync_fifo_vr;

   localparam int LA    = 2;
   localparam int LD    = 8;
   localparam int DEPTH = 4;
   localparam int AFULL = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstn;
   logic          flush_a, iv_a, ordy_a, flush_b, iv_b, ordy_b;
   logic [LD-1:0] id_a, id_b;
   logic          ir_a, ov_a, af_a, of_a, ir_b, ov_b, af_b, of_b;
   logic [LD-1:0] od_a, od_b;
   logic [LA:0]   cnt_dut_a, cnt_dut_b;

   sync_fifo_vr #(.LEN_DATA(LD), .LEN_ADDR(LA), .AFULL_TH(AFULL), .FWFT(1)) dut_a (
      .clk(clk), .rstn(rstn), .flush(flush_a), .i_valid(iv_a), .i_data(id_a),
      .i_ready(ir_a), .o_ready(ordy_a), .o_valid(ov_a), .o_data(od_a),
      .count(cnt_dut_a), .almost_full(af_a), .overflow(of_a));

   sync_fifo_vr #(.LEN_DATA(LD), .LEN_ADDR(LA), .AFULL_TH(AFULL), .FWFT(0)) dut_b (
      .clk(clk), .rstn(rstn), .flush(flush_b), .i_valid(iv_b), .i_data(id_b),
      .i_ready(ir_b), .o_ready(ordy_b), .o_valid(ov_b), .o_data(od_b),
      .count(cnt_dut_b), .almost_full(af_b), .overflow(of_b));

   int checks = 0;
   int errors = 0;

   logic [LD-1:0] exp_a[$];
   logic [LD-1:0] exp_b[$];
   int            cnt_a, cnt_b;
   bit            rdy_a, rdy_b, ovf_a, ovf_b, pulse_b;
   logic [LD-1:0] last_b;
   bit            mon_en = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // FWFT monitor: a word is consumed when head is valid and taken.
   always @(negedge clk) begin
      if (mon_en && rstn && !flush_a && ov_a && ordy_a) begin
         if (exp_a.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected_word: got 0x%0h expected none at %0t", od_a, $time);
         end else begin
            chk("a_data", int'(od_a), int'(exp_a.pop_front()));
         end
      end
   end

   // Request-mode monitor: each done pulse delivers one word; otherwise
   // o_data must hold the last delivered word.
   always @(negedge clk) begin
      if (mon_en) begin
         if (ov_b) begin
            if (exp_b.size() == 0) begin
               checks++; errors++;
               $display("FAIL b_unexpected_pulse: got 0x%0h expected none at %0t", od_b, $time);
            end else begin
               last_b = exp_b.pop_front();
               chk("b_data", int'(od_b), int'(last_b));
            end
         end else begin
            chk("b_hold", int'(od_b), int'(last_b));
         end
      end
   end

   // Advance one clock: update the reference models with the inputs that
   // were sampled on this edge, then compare the registered outputs.
   task automatic step();
      bit push, pop;
      @(posedge clk);
      if (!rstn) begin
         cnt_a = 0; rdy_a = 0; ovf_a = 0; exp_a.delete();
      end else if (flush_a) begin
         cnt_a = 0; rdy_a = 1; ovf_a = 0; exp_a.delete();
      end else begin
         push = iv_a && rdy_a;
         pop  = (cnt_a > 0) && ordy_a;
         if (iv_a && !rdy_a) ovf_a = 1;
         if (push) exp_a.push_back(id_a);
         cnt_a = cnt_a + int'(push) - int'(pop);
         rdy_a = (cnt_a < DEPTH);
      end
      if (!rstn) begin
         cnt_b = 0; rdy_b = 0; ovf_b = 0; pulse_b = 0; last_b = '0; exp_b.delete();
      end else if (flush_b) begin
         cnt_b = 0; rdy_b = 1; ovf_b = 0; pulse_b = 0; exp_b.delete();
      end else begin
         push = iv_b && rdy_b;
         pop  = ordy_b && ((cnt_b > 0) || push);
         if (iv_b && !rdy_b) ovf_b = 1;
         if (push) exp_b.push_back(id_b);
         cnt_b   = cnt_b + int'(push) - int'(pop);
         rdy_b   = (cnt_b < DEPTH);
         pulse_b = pop;
      end
      #1;
      chk("a_count",  int'(cnt_dut_a), cnt_a);
      chk("a_iready", int'(ir_a), int'(rdy_a));
      chk("a_afull",  int'(af_a), int'(cnt_a >= AFULL));
      chk("a_ovf",    int'(of_a), int'(ovf_a));
      chk("a_ovalid", int'(ov_a), int'(cnt_a > 0));
      chk("b_count",  int'(cnt_dut_b), cnt_b);
      chk("b_iready", int'(ir_b), int'(rdy_b));
      chk("b_afull",  int'(af_b), int'(cnt_b >= AFULL));
      chk("b_ovf",    int'(of_b), int'(ovf_b));
      chk("b_ovalid", int'(ov_b), int'(pulse_b));
   endtask

   task automatic drv_a(input bit v, input logic [LD-1:0] d, input bit r, input bit f);
      iv_a = v; id_a = d; ordy_a = r; flush_a = f;
   endtask

   task automatic drv_b(input bit v, input logic [LD-1:0] d, input bit r, input bit f);
      iv_b = v; id_b = d; ordy_b = r; flush_b = f;
   endtask

   initial begin
      int pw, pr;
      rstn = 1'b0;
      drv_a(0, 8'h00, 0, 0);
      drv_b(0, 8'h00, 0, 0);
      last_b = '0;
      step();
      mon_en = 1'b1;
      step();
      rstn = 1'b1;
      step();

      // Fill/drain and overflow on the FWFT instance.
      for (int i = 1; i <= 4; i++) begin
         drv_a(1, 8'(8'h11 * i), 0, 0);
         step();
      end
      drv_a(1, 8'h55, 0, 0);
      step();
      drv_a(0, 8'h00, 0, 0);
      step();
      drv_a(0, 8'h00, 1, 0);
      repeat (4) step();
      drv_a(0, 8'h00, 0, 0);
      step();
      chk("a_drained", exp_a.size(), 0);
      drv_a(0, 8'h00, 0, 1);
      step();
      drv_a(0, 8'h00, 0, 0);
      step();

      // Wrap-around: push/pop pairs at count=1.
      drv_a(1, 8'h01, 0, 0);
      step();
      for (int k = 2; k <= 10; k++) begin
         drv_a(1, 8'(k), 1, 0);
         step();
      end
      drv_a(0, 8'h00, 1, 0);
      step();
      drv_a(0, 8'h00, 0, 0);
      step();
      chk("a_wrap_drained", exp_a.size(), 0);

      // Simultaneous push+pop at count=3, then flush over push+pop.
      for (int i = 0; i < 3; i++) begin
         drv_a(1, 8'(8'hA0 + i), 0, 0);
         step();
      end
      drv_a(1, 8'hA3, 1, 0);
      step();
      drv_a(1, 8'hA4, 1, 1);
      step();
      drv_a(0, 8'h00, 0, 0);
      step();

      // Request mode: bypass read, then a read on empty is ignored.
      drv_b(1, 8'hA5, 1, 0);
      step();
      drv_b(0, 8'h00, 0, 0);
      step();
      drv_b(0, 8'h00, 1, 0);
      step();
      drv_b(0, 8'h00, 0, 0);
      step();
      chk("b_last_a5", int'(od_b), 8'hA5);
      for (int i = 0; i < 4; i++) begin
         drv_b(1, 8'(8'hC0 + i), 0, 0);
         step();
      end
      drv_b(0, 8'h00, 1, 0);
      repeat (5) step();
      drv_b(0, 8'h00, 0, 0);
      step();

      // Reset mid-stream at count=3 on both instances.
      for (int i = 0; i < 3; i++) begin
         drv_a(1, 8'(8'hE0 + i), 0, 0);
         drv_b(1, 8'(8'hF0 + i), 0, 0);
         step();
      end
      drv_a(0, 8'h00, 0, 0);
      drv_b(0, 8'h00, 0, 0);
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      step();
      step();

      // Randomised traffic with phases of different write/read pressure.
      pw = 50; pr = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) begin
            pw = int'($urandom_range(10, 95));
            pr = int'($urandom_range(10, 95));
         end
         drv_a(int'($urandom_range(0, 99)) < pw, 8'($urandom),
               int'($urandom_range(0, 99)) < pr, $urandom_range(0, 99) < 2);
         drv_b(int'($urandom_range(0, 99)) < pw, 8'($urandom),
               int'($urandom_range(0, 99)) < pr, $urandom_range(0, 99) < 2);
         rstn = !($urandom_range(0, 199) == 0);
         step();
      end
      drv_a(0, 8'h00, 0, 0);
      drv_b(0, 8'h00, 0, 0);
      rstn = 1'b1;
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
